// File: rtl/bitserial_mac_seq.sv
// Self-sequenced bit-serial dot-product unit: one weight bit-plane per beat, MSB first,
// runtime precision, signed/unsigned weights, saturating output with optional max-pooling.
module bitserial_mac_seq #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned VEC_LENGTH   = 16,
  parameter int unsigned W_MAX_BITS   = 8,
  parameter int unsigned ACC_WIDTH    = DATA_WIDTH + W_MAX_BITS + $clog2(VEC_LENGTH),
  parameter int unsigned RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act,
  input  logic [VEC_LENGTH-1:0]                  w_bit,
  input  logic [$clog2(W_MAX_BITS+1)-1:0]        w_prec,
  input  logic                                   w_signed,
  input  logic                                   is_pooling,
  input  logic [RESULT_WIDTH-1:0]                pool_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RESULT_WIDTH-1:0]                result
);

  localparam int unsigned PW = $clog2(W_MAX_BITS + 1);

  localparam logic signed [ACC_WIDTH-1:0] ResMax =
    {{(ACC_WIDTH - RESULT_WIDTH + 1){1'b0}}, {(RESULT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ResMin =
    {{(ACC_WIDTH - RESULT_WIDTH + 1){1'b1}}, {(RESULT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                                state_q;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
  logic [PW-1:0]                         prec_q;
  logic [PW-1:0]                         cnt_q;
  logic                                  signed_q;
  logic                                  pool_q;
  logic [RESULT_WIDTH-1:0]               pool_in_q;
  logic signed [ACC_WIDTH-1:0]           psum_q;
  logic signed [ACC_WIDTH-1:0]           acc_q;
  logic                                  pipe_valid_q;
  logic                                  pipe_first_q;
  logic                                  in_ready_q;
  logic                                  out_valid_q;
  logic [RESULT_WIDTH-1:0]               result_q;

  logic                                  accept;
  logic                                  first_beat;
  logic [PW-1:0]                         prec_in_eff;
  logic [PW-1:0]                         prec_cur;
  logic                                  signed_cur;
  logic [PW-1:0]                         cnt_nxt;
  logic                                  last_beat;
  logic signed [ACC_WIDTH-1:0]           lane_sum;
  logic signed [ACC_WIDTH-1:0]           psum_d;
  logic [RESULT_WIDTH-1:0]               sat_val;
  logic [RESULT_WIDTH-1:0]               final_val;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  assign accept     = in_valid & in_ready_q;
  assign first_beat = (state_q == StIdle);

  always_comb begin
    prec_in_eff = w_prec;
    if (w_prec == '0) begin
      prec_in_eff = PW'(1);
    end else if (w_prec > PW'(W_MAX_BITS)) begin
      prec_in_eff = PW'(W_MAX_BITS);
    end
  end

  // Job parameters come straight from the ports on the first beat, from latches afterwards.
  assign prec_cur   = first_beat ? prec_in_eff : prec_q;
  assign signed_cur = first_beat ? w_signed : signed_q;
  assign cnt_nxt    = cnt_q + 1'b1;
  assign last_beat  = (cnt_nxt == prec_cur);

  always_comb begin
    logic [DATA_WIDTH-1:0] a;
    lane_sum = '0;
    for (int j = 0; j < int'(VEC_LENGTH); j++) begin
      a = first_beat ? act[j] : act_q[j];
      if (w_bit[j]) begin
        lane_sum = lane_sum + {{(ACC_WIDTH - DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
      end
    end
  end

  // The MSB plane of a signed weight carries weight -2^(P-1).
  assign psum_d = (first_beat && signed_cur) ? -lane_sum : lane_sum;

  always_comb begin
    if (acc_q > ResMax) begin
      sat_val = ResMax[RESULT_WIDTH-1:0];
    end else if (acc_q < ResMin) begin
      sat_val = ResMin[RESULT_WIDTH-1:0];
    end else begin
      sat_val = acc_q[RESULT_WIDTH-1:0];
    end
    final_val = sat_val;
    if (pool_q && ($signed(pool_in_q) > $signed(sat_val))) begin
      final_val = pool_in_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      act_q        <= '0;
      prec_q       <= '0;
      cnt_q        <= '0;
      signed_q     <= 1'b0;
      pool_q       <= 1'b0;
      pool_in_q    <= '0;
      psum_q       <= '0;
      acc_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_first_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
    end else begin
      pipe_valid_q <= accept;
      if (accept) begin
        psum_q       <= psum_d;
        pipe_first_q <= first_beat;
      end
      if (pipe_valid_q) begin
        acc_q <= pipe_first_q ? psum_q : (acc_q <<< 1) + psum_q;
      end

      unique case (state_q)
        StIdle, StRun: begin
          if (accept) begin
            if (first_beat) begin
              act_q     <= act;
              prec_q    <= prec_in_eff;
              signed_q  <= w_signed;
              pool_q    <= is_pooling;
              pool_in_q <= pool_in;
            end
            if (last_beat) begin
              state_q    <= StDrain;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= StRun;
              cnt_q   <= cnt_nxt;
            end
          end
        end
        StDrain: state_q <= StDone;
        StDone: begin
          if (!out_valid_q) begin
            result_q    <= final_val;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
